// File: rtl/window3x3_gen.sv
// window3x3_gen: 3x3 neighbourhood window generator for a raster pixel stream.
// Takes IMG_WIDTH x IMG_HEIGHT pixels in row-major order and emits one window
// per pixel position, centred on that pixel, in raster order. Storage is two
// line buffers plus two stored window columns; the third column is formed from
// the line buffers and the incoming pixel. Border positions are padded.
// Optional build macro WINDOW_BORDER_REPLICATE_EN: padded positions take the
// nearest in-image pixel (clamped per axis) instead of 0.
//
// Handshake: a pixel transfers on a rising edge where in_valid && in_ready;
// a window transfers on a rising edge where out_valid && out_ready. The
// output register (out_window, out_valid, out_last) holds its value while
// out_valid && !out_ready. in_ready never depends on in_valid.
module window3x3_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 100,
  parameter int IMG_HEIGHT = 100,
  parameter int CNT_WIDTH  = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [9*DATA_WIDTH-1:0] out_window,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    frame_done,
  output logic                    busy,
  output logic [2:0]              dbg_state
);

  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [CNT_WIDTH-1:0] PIX_TOTAL = CNT_WIDTH'(IMG_WIDTH * IMG_HEIGHT);
  localparam logic [CNT_WIDTH-1:0] PIX_LAST  = CNT_WIDTH'(IMG_WIDTH * IMG_HEIGHT - 1);
  localparam logic [CNT_WIDTH-1:0] FILL_LAST = CNT_WIDTH'(IMG_WIDTH);
  localparam logic [COL_W-1:0]     LAST_COL  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0]     LAST_ROW  = ROW_W'(IMG_HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, state_next;

  logic [CNT_WIDTH-1:0] in_cnt;
  logic [CNT_WIDTH-1:0] out_cnt;
  logic [COL_W-1:0]     in_col;
  logic [COL_W-1:0]     out_col;
  logic [ROW_W-1:0]     out_row;

  logic [DATA_WIDTH-1:0] lb_top [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb_mid [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] col_a [3];
  logic [DATA_WIDTH-1:0] col_b [3];
  logic [DATA_WIDTH-1:0] nc [3];
  logic [DATA_WIDTH-1:0] raw [3][3];
  logic [9*DATA_WIDTH-1:0] win_next;

  logic out_free, in_acc, flush_emit, shift_en, load;
  logic pad_top, pad_bot, pad_left, pad_right;

  assign out_free   = !out_valid || out_ready;
  assign in_acc     = in_valid && in_ready;
  assign flush_emit = (state == S_FLUSH) && out_free && (out_cnt != PIX_TOTAL);
  assign shift_en   = in_acc || flush_emit;
  assign load       = ((state == S_RUN) && in_acc) || flush_emit;
  assign dbg_state  = state;

  assign pad_top   = (out_row == '0);
  assign pad_bot   = (out_row == LAST_ROW);
  assign pad_left  = (out_col == '0);
  assign pad_right = (out_col == LAST_COL);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state decode and handshake/status outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    frame_done = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start) state_next = S_FILL;
      end
      S_FILL: begin
        in_ready = 1'b1;
        if (in_valid && in_cnt == FILL_LAST) state_next = S_RUN;
      end
      S_RUN: begin
        in_ready = out_free;
        if (in_valid && out_free && in_cnt == PIX_LAST) state_next = S_FLUSH;
      end
      S_FLUSH: begin
        if (out_valid && out_ready && out_last) state_next = S_DONE;
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Input-side and centre-position counters; cleared when a frame is armed.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt  <= '0;
      in_col  <= '0;
      out_cnt <= '0;
      out_col <= '0;
      out_row <= '0;
    end else if (state == S_IDLE) begin
      if (start) begin
        in_cnt  <= '0;
        in_col  <= '0;
        out_cnt <= '0;
        out_col <= '0;
        out_row <= '0;
      end
    end else begin
      if (in_acc) in_cnt <= in_cnt + 1'b1;
      if (shift_en) in_col <= (in_col == LAST_COL) ? '0 : in_col + 1'b1;
      if (load) begin
        out_cnt <= out_cnt + 1'b1;
        if (out_col == LAST_COL) begin
          out_col <= '0;
          out_row <= out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
      end
    end
  end

  // Line buffers: lb_mid holds the previous row, lb_top the one before it.
  // Contents survive reset; stale entries are always hidden by padding.
  always_ff @(posedge clk) begin
    if (in_acc) begin
      lb_top[in_col] <= lb_mid[in_col];
      lb_mid[in_col] <= in_data;
    end
  end

  // Column formed from the line buffers and the new pixel; during flush the
  // bottom row is beyond the image and is always padded.
  always_comb begin
    nc[0] = lb_top[in_col];
    nc[1] = lb_mid[in_col];
    nc[2] = (state == S_FLUSH) ? '0 : in_data;
  end

  // Stored window columns shift left by one on every accepted or flushed position.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      for (int i = 0; i < 3; i++) begin
        col_a[i] <= col_b[i];
        col_b[i] <= nc[i];
      end
    end
  end

  // Assemble the unpadded 3x3 neighbourhood: left, centre, right columns.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      raw[i][0] = col_a[i];
      raw[i][1] = col_b[i];
      raw[i][2] = nc[i];
    end
  end

  // Apply border padding from the centre coordinates.
  always_comb begin
`ifdef WINDOW_BORDER_REPLICATE_EN
    logic [1:0] ri;
    logic [1:0] cj;
    win_next = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        ri = 2'(i);
        cj = 2'(j);
        if ((i == 0 && pad_top) || (i == 2 && pad_bot))    ri = 2'd1;
        if ((j == 0 && pad_left) || (j == 2 && pad_right)) cj = 2'd1;
        win_next[DATA_WIDTH*(3*i+j) +: DATA_WIDTH] = raw[ri][cj];
      end
    end
`else
    win_next = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if ((i == 0 && pad_top) || (i == 2 && pad_bot) ||
            (j == 0 && pad_left) || (j == 2 && pad_right))
          win_next[DATA_WIDTH*(3*i+j) +: DATA_WIDTH] = '0;
        else
          win_next[DATA_WIDTH*(3*i+j) +: DATA_WIDTH] = raw[i][j];
      end
    end
`endif
  end

  // Output register: load a new window when free, otherwise hold until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_window <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
    end else if (load) begin
      out_window <= win_next;
      out_valid  <= 1'b1;
      out_last   <= (out_cnt == PIX_LAST);
    end else if (out_ready) begin
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_window3x3_gen.sv
// tb_window3x3_gen: directed bench for window3x3_gen with a small 4x3 instance
// (hand-computed windows) and a default 100x100 instance (reference model).
module tb_window3x3_gen;

  localparam int DW = 8;
  localparam int SW = 4;
  localparam int SH = 3;
  localparam int SN = SW * SH;
  localparam int LW = 100;
  localparam int LH = 100;
  localparam int LN = LW * LH;

  // Clock and reset.
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Small instance signals.
  logic          s_start, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic          s_out_last, s_frame_done, s_busy;
  logic [DW-1:0] s_in_data;
  logic [9*DW-1:0] s_out_window;
  logic [2:0]    s_dbg;

  // Large instance signals.
  logic          l_start, l_in_valid, l_in_ready, l_out_valid, l_out_ready;
  logic          l_out_last, l_frame_done, l_busy;
  logic [DW-1:0] l_in_data;
  logic [9*DW-1:0] l_out_window;
  logic [2:0]    l_dbg;

  window3x3_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(SW), .IMG_HEIGHT(SH), .CNT_WIDTH(6)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .in_valid(s_in_valid), .in_data(s_in_data),
    .in_ready(s_in_ready), .out_valid(s_out_valid), .out_window(s_out_window),
    .out_ready(s_out_ready), .out_last(s_out_last), .frame_done(s_frame_done),
    .busy(s_busy), .dbg_state(s_dbg)
  );

  window3x3_gen dut_l (
    .clk(clk), .rst(rst), .start(l_start), .in_valid(l_in_valid), .in_data(l_in_data),
    .in_ready(l_in_ready), .out_valid(l_out_valid), .out_window(l_out_window),
    .out_ready(l_out_ready), .out_last(l_out_last), .frame_done(l_frame_done),
    .busy(l_busy), .dbg_state(l_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0]   pix [0:LN-1];
  logic [9*DW-1:0] s_got [0:SN-1];
  logic [9*DW-1:0] exp_q [$];
  int s_nwin, s_nlast, s_last_idx, s_last_cyc, s_done_cyc, s_extra_in, s_idle_acc;
  logic [9*DW-1:0] l_win5;

  // Reference window from the pixel array; rows/cols outside the image pad.
  function automatic logic [9*DW-1:0] model_win(input int w, input int h, input int r, input int c);
    logic [9*DW-1:0] res;
    int rr, cc;
    res = '0;
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        rr = r + dr - 1;
        cc = c + dc - 1;
`ifdef WINDOW_BORDER_REPLICATE_EN
        if (rr < 0)  rr = 0;
        if (rr >= h) rr = h - 1;
        if (cc < 0)  cc = 0;
        if (cc >= w) cc = w - 1;
        res[DW*(3*dr+dc) +: DW] = pix[rr*w+cc];
`else
        if (rr >= 0 && rr < h && cc >= 0 && cc < w)
          res[DW*(3*dr+dc) +: DW] = pix[rr*w+cc];
`endif
      end
    end
    return res;
  endfunction

  // Drive one 4x3 ramp frame; noisy adds idle/flush in_valid and a RUN start pulse.
  task automatic run_small(input bit noisy);
    int idx, cyc;
    s_nwin = 0; s_nlast = 0; s_last_idx = -1; s_last_cyc = -1; s_done_cyc = -1;
    s_extra_in = 0; s_idle_acc = 0;
    for (int i = 0; i < SN; i++) pix[i] = DW'(i);
    if (noisy) begin
      repeat (3) begin
        @(posedge clk); #1;
        s_in_valid = 1'b1; s_in_data = 8'hEE;
        @(negedge clk);
        if (s_in_ready) s_idle_acc++;
      end
    end
    @(posedge clk); #1;
    s_start = 1'b1; s_in_valid = noisy; s_in_data = 8'hEE; s_out_ready = 1'b1;
    idx = 0; cyc = 0;
    while (s_done_cyc < 0 && cyc < 200) begin
      @(posedge clk); #1;
      s_start = noisy && (idx == 7);
      if (idx < SN) begin
        s_in_valid = 1'b1; s_in_data = pix[idx];
      end else begin
        s_in_valid = noisy; s_in_data = 8'hEE;
      end
      s_out_ready = 1'b1;
      @(negedge clk);
      if (s_in_valid && s_in_ready) begin
        if (idx < SN) idx++;
        else s_extra_in++;
      end
      if (s_frame_done) s_done_cyc = cyc;
      if (s_out_valid && s_out_ready) begin
        if (s_nwin < SN) s_got[s_nwin] = s_out_window;
        if (s_out_last) begin
          s_nlast++; s_last_idx = s_nwin; s_last_cyc = cyc;
        end
        s_nwin++;
      end
      cyc++;
    end
    @(posedge clk); #1;
    s_in_valid = 1'b0; s_start = 1'b0;
    if (s_done_cyc < 0) begin
      n_checks++; n_fail++;
      $display("FAIL small_timeout: frame_done not seen within %0d cycles", cyc);
    end
  endtask

  // Drive a 100x100 frame (optionally stopping after stop_after pixels) and
  // check every window against the model plus output stability during stalls.
  task automatic run_large(input int pat, input bit rnd, input int stop_after);
    int idx, nwin, cyc;
    bit held, done;
    logic [9*DW-1:0] held_win, expw;
    for (int r = 0; r < LH; r++)
      for (int c = 0; c < LW; c++)
        pix[r*LW+c] = (pat == 0) ? DW'(r*13 + c*7 + 1) : DW'(r*5 + c*11 + 200);
    @(posedge clk); #1;
    l_start = 1'b1; l_in_valid = 1'b0; l_out_ready = 1'b1;
    idx = 0; nwin = 0; cyc = 0; held = 0; done = 0;
    while (!done && cyc < 60000) begin
      @(posedge clk); #1;
      l_start = 1'b0;
      if (idx < stop_after) begin
        l_in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        l_in_data  = pix[idx];
      end else begin
        l_in_valid = 1'b0;
      end
      l_out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      if (held) begin
        n_checks++;
        if (l_out_valid !== 1'b1 || l_out_window !== held_win) begin
          n_fail++;
          $display("FAIL stall_stable win %0d: got v=%0b %h, want v=1 %h", nwin, l_out_valid, l_out_window, held_win);
        end
      end
      held = l_out_valid && !l_out_ready;
      held_win = l_out_window;
      if (l_in_valid && l_in_ready) idx++;
      if (l_out_valid && l_out_ready) begin
        expw = model_win(LW, LH, nwin / LW, nwin % LW);
        if (nwin == 5) l_win5 = l_out_window;
        n_checks++;
        if (l_out_window !== expw || l_out_last !== (nwin == LN - 1)) begin
          n_fail++;
          $display("FAIL large_window %0d: got %h last=%0b, want %h last=%0b", nwin, l_out_window, l_out_last, expw, (nwin == LN - 1));
        end
        nwin++;
      end
      if (l_frame_done) done = 1;
      if (stop_after < LN && idx >= stop_after) done = 1;
      cyc++;
    end
    if (stop_after == LN) begin
      n_checks++;
      if (!l_frame_done || nwin != LN) begin
        n_fail++;
        $display("FAIL large_count: got %0d windows done=%0b, want %0d windows done=1", nwin, l_frame_done, LN);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_start = 0; s_in_valid = 0; s_in_data = '0; s_out_ready = 1;
    l_start = 0; l_in_valid = 0; l_in_data = '0; l_out_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({s_in_ready, s_out_valid, s_out_last, s_frame_done, s_busy} !== 5'b0 || s_dbg !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_small_ctrl: got %b dbg=%0d, want 00000 dbg=0",
               {s_in_ready, s_out_valid, s_out_last, s_frame_done, s_busy}, s_dbg);
    end
    n_checks++;
    if (s_out_window !== '0) begin
      n_fail++;
      $display("FAIL reset_small_window: got %h, want 0", s_out_window);
    end
    n_checks++;
    if ({l_in_ready, l_out_valid, l_out_last, l_frame_done, l_busy} !== 5'b0 || l_out_window !== '0) begin
      n_fail++;
      $display("FAIL reset_large: got ctrl %b win %h, want 00000 and 0",
               {l_in_ready, l_out_valid, l_out_last, l_frame_done, l_busy}, l_out_window);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_ramp_frame();
    logic [9*DW-1:0] e11, e00, e23, expw;
    e11 = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
`ifdef WINDOW_BORDER_REPLICATE_EN
    e00 = {8'd5, 8'd4, 8'd4, 8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0};
    e23 = {8'd11, 8'd11, 8'd10, 8'd11, 8'd11, 8'd10, 8'd7, 8'd7, 8'd6};
`else
    e00 = {8'd5, 8'd4, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    e23 = {8'd0, 8'd0, 8'd0, 8'd0, 8'd11, 8'd10, 8'd0, 8'd7, 8'd6};
`endif
    run_small(1'b0);
    n_checks++;
    if (s_nwin != SN) begin n_fail++; $display("FAIL ramp_count: got %0d, want %0d", s_nwin, SN); end
    n_checks++;
    if (s_nlast != 1 || s_last_idx != SN - 1) begin
      n_fail++; $display("FAIL ramp_last: got count %0d at idx %0d, want 1 at %0d", s_nlast, s_last_idx, SN - 1);
    end
    n_checks++;
    if (s_done_cyc != s_last_cyc + 1) begin
      n_fail++; $display("FAIL ramp_done_timing: got cycle %0d, want %0d", s_done_cyc, s_last_cyc + 1);
    end
    n_checks++;
    if (s_got[5] !== e11) begin n_fail++; $display("FAIL ramp_centre_1_1: got %h, want %h", s_got[5], e11); end
    n_checks++;
    if (s_got[0] !== e00) begin n_fail++; $display("FAIL ramp_centre_0_0: got %h, want %h", s_got[0], e00); end
    n_checks++;
    if (s_got[11] !== e23) begin n_fail++; $display("FAIL ramp_centre_2_3: got %h, want %h", s_got[11], e23); end
    exp_q.delete();
    for (int k = 0; k < SN; k++) exp_q.push_back(model_win(SW, SH, k / SW, k % SW));
    for (int k = 0; k < SN; k++) begin
      expw = exp_q.pop_front();
      n_checks++;
      if (s_got[k] !== expw) begin n_fail++; $display("FAIL ramp_window %0d: got %h, want %h", k, s_got[k], expw); end
    end
    @(negedge clk);
    n_checks++;
    if (s_busy !== 1'b0 || s_frame_done !== 1'b0) begin
      n_fail++; $display("FAIL ramp_idle_after: got busy=%0b done=%0b, want 0 0", s_busy, s_frame_done);
    end
  endtask

  task automatic test_ignore_controls();
    logic [9*DW-1:0] expw;
    run_small(1'b1);
    n_checks++;
    if (s_idle_acc != 0 || s_extra_in != 0) begin
      n_fail++; $display("FAIL ignore_in_valid: got idle_acc=%0d extra=%0d, want 0 0", s_idle_acc, s_extra_in);
    end
    n_checks++;
    if (s_nwin != SN || s_last_idx != SN - 1) begin
      n_fail++; $display("FAIL ignore_count: got %0d last@%0d, want %0d last@%0d", s_nwin, s_last_idx, SN, SN - 1);
    end
    for (int k = 0; k < SN; k++) begin
      expw = model_win(SW, SH, k / SW, k % SW);
      n_checks++;
      if (s_got[k] !== expw) begin n_fail++; $display("FAIL ignore_window %0d: got %h, want %h", k, s_got[k], expw); end
    end
  endtask

  task automatic test_random_frame();
    run_large(0, 1'b1, LN);
  endtask

  task automatic test_reset_mid_frame();
    logic [3*DW-1:0] top_exp;
    run_large(0, 1'b0, 250);
    @(posedge clk); #1;
    rst = 1'b1; l_in_valid = 1'b0; l_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({l_in_ready, l_out_valid, l_out_last, l_frame_done, l_busy} !== 5'b0 || l_out_window !== '0 || l_dbg !== 3'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got ctrl %b win %h dbg %0d, want 00000 0 0",
               {l_in_ready, l_out_valid, l_out_last, l_frame_done, l_busy}, l_out_window, l_dbg);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    run_large(1, 1'b1, LN);
`ifdef WINDOW_BORDER_REPLICATE_EN
    top_exp = {pix[6], pix[5], pix[4]};
`else
    top_exp = '0;
`endif
    n_checks++;
    if (l_win5[3*DW-1:0] !== top_exp) begin
      n_fail++; $display("FAIL midreset_top_row: got %h, want %h", l_win5[3*DW-1:0], top_exp);
    end
  endtask

  initial begin
    test_reset();
    test_ramp_frame();
    test_ignore_controls();
    test_random_frame();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/window3x3_gen.md
Name: window3x3_gen

Overview:
- Upstream neighbour of the sobel and median stages.
- Accepts the raster pixel stream that follows the 1078-byte BMP header: row-major, IMG_WIDTH x IMG_HEIGHT, DATA_WIDTH bits per pixel.
- Emits one 3x3 neighbourhood window per pixel position, centred on that pixel, in raster order, so both filters see exactly IMG_WIDTH*IMG_HEIGHT windows per frame.
- Internal storage: two line buffers plus a 3x3 register array; border windows are padded.

Parameters:
- DATA_WIDTH, 8: pixel width in bits.
- IMG_WIDTH, 100: pixels per row; must be >= 2.
- IMG_HEIGHT, 100: rows per frame; must be >= 2.
- CNT_WIDTH, 14: width of the pixel/window counters; must satisfy 2^CNT_WIDTH > IMG_WIDTH*IMG_HEIGHT.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; arms a frame. Sampled only in IDLE.
- in_valid  in  1  pixel on in_data is valid.
- in_data  in  DATA_WIDTH  pixel value.
- in_ready  out  1  block accepts in_data this cycle.
- out_valid  out  1  window is valid.
- out_window  out  9*DATA_WIDTH  element w_i is at bits [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i]. w0 = top-left, w4 = centre, w8 = bottom-right, row-major order.
- out_ready  in  1  downstream accepts the window.
- out_last  out  1  high with the final window of the frame.
- frame_done  out  1  one-cycle pulse after the last window is accepted.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, active-high), including mid-frame:
  - state = IDLE; all counters = 0.
  - in_ready, out_valid, out_last, frame_done, busy = 0; out_window = 0.
  - Line-buffer contents are not cleared; padding masks make this safe.
- Transfer rule: input transfers when in_valid && in_ready; output transfers when out_valid && out_ready.
- Output register: out_window, out_valid and out_last are registered and held stable while out_valid && !out_ready.
- States:
  - IDLE: in_ready = 0. start -> FILL.
  - FILL: in_ready = 1, no output. After IMG_WIDTH+1 pixels have been accepted -> RUN.
  - RUN: in_ready = !out_valid || out_ready.
    - Each accepted pixel k produces the window centred at pixel k-IMG_WIDTH-1.
    - out_valid rises the cycle after the accepting edge (latency: 1 cycle after the enabling input).
    - When input count reaches IMG_WIDTH*IMG_HEIGHT -> FLUSH.
  - FLUSH: in_ready = 0. Emits the remaining IMG_WIDTH+1 windows with the bottom row padded, one per cycle whenever the output register is free. The final window has out_last = 1; when it is accepted -> DONE.
  - DONE: frame_done = 1 for one cycle -> IDLE.
- Counters:
  - in_cnt counts accepted pixels.
  - out_row/out_col track the centre position; out_col wraps at IMG_WIDTH-1 and increments out_row.
- Padding, decided from the centre coordinates (r, c):
  - r == 0: top row padded.
  - r == IMG_HEIGHT-1: bottom row padded.
  - c == 0: left column padded.
  - c == IMG_WIDTH-1: right column padded.
  - Corners apply both rules.
  - Pixels from the previous row's wrap must never appear in a window.
- Default padding value is 0.
- Boundary cases:
  - start outside IDLE is ignored.
  - in_valid in IDLE, FLUSH or DONE is ignored; no data is lost because in_ready = 0.
  - Simultaneous accept-in and accept-out in RUN sustains one window per cycle.
- Total: exactly IMG_WIDTH*IMG_HEIGHT windows per frame; out_last coincides with centre (IMG_HEIGHT-1, IMG_WIDTH-1).

Optional Feature:
- Macro: WINDOW_BORDER_REPLICATE_EN.
- Defined: padded positions take the nearest in-image pixel (edge replicate, clamped per axis).
- Undefined: padded positions are 0.
- All other timing, handshake behaviour and window counts are identical in both builds.

Test Plan:
1. IMG_WIDTH=4, IMG_HEIGHT=3, ramp input pixel(r,c) = 4r+c, out_ready held 1 -> window centre (1,1) = {0,1,2,4,5,6,8,9,10}; centre (0,0) = {0,0,0,0,0,1,0,4,5}; centre (2,3) = {6,7,0,10,11,0,0,0,0}; 12 windows total; out_last on the 12th; frame_done one cycle later.
2. Same frame with WINDOW_BORDER_REPLICATE_EN defined -> centre (0,0) = {0,0,1,0,0,1,4,4,5}; centre (2,3) = {6,7,7,10,11,11,10,11,11}.
3. Default 100x100 frame, random in_valid and random out_ready -> exactly 10000 windows, each equal to the software model; out_window stable during every stall; no input accepted while in_ready = 0.
4. rst asserted after 250 pixels of a 100x100 frame, then a new start and full frame -> all outputs 0 the cycle after reset; second frame's windows correct with no stale top-row data (centre (0,5) top row = 0,0,0).
5. start pulsed during RUN and in_valid high during IDLE/FLUSH -> no state change and no extra accepted pixels; window count unchanged.
